addsub_arbiter: RTL and testbench

Sequential arbiter and controller for the shared 16-bit saturating add/sub datapath. Two independent requesters, for example the execute stage and the address/reduction sequencer, issue operations over valid/ready handshakes. A round-robin grant selects one operation, which is sequenced through the datapath; a registered result, status flags and a one-cycle response pulse are returned to the requester that issued it. One operation is in flight at a time.

---
 rtl/addsub_arbiter.sv | 118 +++++++++++
 tb/tb_addsub_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter and sequencer for two requesters sharing one 16-bit
// saturating add/sub datapath; one operation in flight, result returned after 2 cycles.
module addsub_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_result,
  output logic [2:0]       resp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic             sub_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       flags_q;
  logic             resp0_q;
  logic             resp1_q;

  logic [1:0]       valid_w;
  logic [1:0]       ready_w;
  logic             grant;
  logic             is_idle;
  logic             handshake;

  // Alternate under contention; otherwise the sole valid requester wins.
  assign grant     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign is_idle   = (state_q == IDLE) & ~rst;
  assign valid_w   = {req1_valid, req0_valid};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_w[gi] = is_idle & valid_w[gi] & (grant == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_w[0];
  assign req1_ready = ready_w[1];
  assign handshake  = |ready_w;

  logic [WIDTH-1:0] op_b_eff;
  logic [WIDTH-1:0] raw_sum;
  logic             ovf;
  logic [WIDTH-1:0] result_d;
  logic [2:0]       flags_d;

  // Subtraction is A + ~B + 1; overflow when like-signed operands yield an unlike sign.
  assign op_b_eff = sub_q ? ~b_q : b_q;
  assign raw_sum  = a_q + op_b_eff + {{(WIDTH-1){1'b0}}, sub_q};
  assign ovf      = (a_q[WIDTH-1] == op_b_eff[WIDTH-1]) & (raw_sum[WIDTH-1] != a_q[WIDTH-1]);
  assign result_d = !ovf          ? raw_sum :
                    a_q[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                    {1'b0, {(WIDTH-1){1'b1}}};
  assign flags_d  = {result_d[WIDTH-1], ovf, (result_d == '0)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      sub_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      flags_q      <= 3'b000;
      resp0_q      <= 1'b0;
      resp1_q      <= 1'b0;
    end else begin
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (handshake) begin
            a_q          <= grant ? req1_a : req0_a;
            b_q          <= grant ? req1_b : req0_b;
            sub_q        <= grant ? req1_sub : req0_sub;
            owner_q      <= grant;
            last_grant_q <= grant;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          result_q <= result_d;
          flags_q  <= flags_d;
          resp0_q  <= ~owner_q;
          resp1_q  <= owner_q;
          state_q  <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp0_valid = resp0_q;
  assign resp1_valid = resp1_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed scenarios plus randomized traffic scored
// against a signed-integer saturating model and a cycle-level arbitration model.
module tb_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [15:0] resp_result;
  logic [2:0]  resp_flags;

  int pass_cnt = 0;
  int total_cnt = 0;

  addsub_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_result(resp_result), .resp_flags(resp_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int p, input logic v, input logic [15:0] a, input logic [15:0] b, input logic s);
    if (p == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_sub = s; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; req1_sub = s; end
  endtask

  function automatic logic get_ready(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic get_resp(input int p);
    return (p == 0) ? resp0_valid : resp1_valid;
  endfunction

  // Reference: exact signed arithmetic, clamped to the 16-bit range.
  function automatic void ref_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 output logic [15:0] r, output logic [2:0] f);
    int sum;
    logic v;
    sum = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    v = (sum > 32767) || (sum < -32768);
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    r = sum[15:0];
    f = {r[15], v, (r == 16'h0000)};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents an op and holds it until ready; returns at the negedge of the EXEC cycle.
  task automatic issue(input int p, input logic [15:0] a, input logic [15:0] b, input logic s, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    drive(p, 1'b1, a, b, s);
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (get_ready(p)) ok = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    drive(p, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    repeat (3) begin
      @(negedge clk); #1;
      total_cnt++; if (req0_ready !== 1'b0) $display("FAIL reset_ready0: got %b expected 0", req0_ready); else pass_cnt++;
      total_cnt++; if (resp0_valid !== 1'b0) $display("FAIL reset_resp0: got %b expected 0", resp0_valid); else pass_cnt++;
      total_cnt++; if (resp1_valid !== 1'b0) $display("FAIL reset_resp1: got %b expected 0", resp1_valid); else pass_cnt++;
      total_cnt++; if (resp_result !== 16'h0000) $display("FAIL reset_result: got %h expected 0000", resp_result); else pass_cnt++;
      total_cnt++; if (resp_flags !== 3'b000) $display("FAIL reset_flags: got %b expected 000", resp_flags); else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL post_reset_ready0: got %b expected 1", req0_ready); else pass_cnt++;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    $display("reset: released with req0_valid held, ready=%b", req0_ready);
  endtask

  task automatic test_single;
    bit ok;
    issue(0, 16'h1234, 16'h0001, 1'b0, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL single_handshake: got %b expected 1", ok); else pass_cnt++;
    total_cnt++; if (resp0_valid !== 1'b0) $display("FAIL single_resp0_exec: got %b expected 0", resp0_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (resp0_valid !== 1'b1) $display("FAIL single_resp0_done: got %b expected 1", resp0_valid); else pass_cnt++;
    total_cnt++; if (resp1_valid !== 1'b0) $display("FAIL single_resp1_done: got %b expected 0", resp1_valid); else pass_cnt++;
    total_cnt++; if (resp_result !== 16'h1235) $display("FAIL single_result: got %h expected 1235", resp_result); else pass_cnt++;
    total_cnt++; if (resp_flags !== 3'b000) $display("FAIL single_flags: got %b expected 000", resp_flags); else pass_cnt++;
    $display("single: req0 1234+0001 -> result=%h flags=%b", resp_result, resp_flags);
    @(negedge clk);
    total_cnt++; if (resp0_valid !== 1'b0) $display("FAIL single_resp0_after: got %b expected 0", resp0_valid); else pass_cnt++;
    total_cnt++; if (resp1_valid !== 1'b0) $display("FAIL single_resp1_after: got %b expected 0", resp1_valid); else pass_cnt++;
  endtask

  task automatic test_saturation;
    int          tp[3] = '{1, 0, 0};
    logic [15:0] ta[3] = '{16'h7FFF, 16'h8000, 16'h0005};
    logic [15:0] tb[3] = '{16'h0001, 16'h0001, 16'h0005};
    logic        ts[3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] tr[3] = '{16'h7FFF, 16'h8000, 16'h0000};
    logic [2:0]  tf[3] = '{3'b010, 3'b110, 3'b001};
    bit ok;
    for (int i = 0; i < 3; i++) begin
      issue(tp[i], ta[i], tb[i], ts[i], ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL sat%0d_handshake: got %b expected 1", i, ok); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (get_resp(tp[i]) !== 1'b1) $display("FAIL sat%0d_resp_owner: got %b expected 1", i, get_resp(tp[i])); else pass_cnt++;
      total_cnt++; if (get_resp(1 - tp[i]) !== 1'b0) $display("FAIL sat%0d_resp_other: got %b expected 0", i, get_resp(1 - tp[i])); else pass_cnt++;
      total_cnt++; if (resp_result !== tr[i]) $display("FAIL sat%0d_result: got %h expected %h", i, resp_result, tr[i]); else pass_cnt++;
      total_cnt++; if (resp_flags !== tf[i]) $display("FAIL sat%0d_flags: got %b expected %b", i, resp_flags, tf[i]); else pass_cnt++;
      $display("sat: req%0d %h %s %h -> result=%h flags=%b", tp[i], ta[i], ts[i] ? "-" : "+", tb[i], resp_result, resp_flags);
      @(negedge clk);
    end
  endtask

  task automatic test_contention;
    int          cnt[2];
    logic [15:0] ca, cb, er;
    logic [2:0]  ef;
    logic        cs, exp_r0, exp_r1, exp_p0, exp_p1;
    int          q;
    do_reset;
    cnt = '{0, 0};
    er = '0;
    ef = '0;
    for (int k = 0; k < 12; k++) begin
      if (k != 0) @(negedge clk);
      exp_p0 = (k % 3 == 2) && ((k / 3) % 2 == 0);
      exp_p1 = (k % 3 == 2) && ((k / 3) % 2 == 1);
      total_cnt++; if (resp0_valid !== exp_p0) $display("FAIL cont_resp0 k=%0d: got %b expected %b", k, resp0_valid, exp_p0); else pass_cnt++;
      total_cnt++; if (resp1_valid !== exp_p1) $display("FAIL cont_resp1 k=%0d: got %b expected %b", k, resp1_valid, exp_p1); else pass_cnt++;
      if (k % 3 == 2) begin
        total_cnt++; if (resp_result !== er) $display("FAIL cont_result k=%0d: got %h expected %h", k, resp_result, er); else pass_cnt++;
        total_cnt++; if (resp_flags !== ef) $display("FAIL cont_flags k=%0d: got %b expected %b", k, resp_flags, ef); else pass_cnt++;
        $display("contention: resp owner=%0d result=%h flags=%b", (k / 3) % 2, resp_result, resp_flags);
      end
      for (int p = 0; p < 2; p++)
        drive(p, 1'b1, 16'(p * 16'h4000 + cnt[p] * 16'h0101 + 16'h0011),
              16'(cnt[p] * 16'h0203 + p + 1), 1'((cnt[p] + p) % 2));
      #1;
      exp_r0 = (k % 3 == 0) && ((k / 3) % 2 == 0);
      exp_r1 = (k % 3 == 0) && ((k / 3) % 2 == 1);
      total_cnt++; if (req0_ready !== exp_r0) $display("FAIL cont_ready0 k=%0d: got %b expected %b", k, req0_ready, exp_r0); else pass_cnt++;
      total_cnt++; if (req1_ready !== exp_r1) $display("FAIL cont_ready1 k=%0d: got %b expected %b", k, req1_ready, exp_r1); else pass_cnt++;
      if (k % 3 == 0) begin
        q  = (k / 3) % 2;
        ca = 16'(q * 16'h4000 + cnt[q] * 16'h0101 + 16'h0011);
        cb = 16'(cnt[q] * 16'h0203 + q + 1);
        cs = 1'((cnt[q] + q) % 2);
        ref_op(ca, cb, cs, er, ef);
        cnt[q]++;
      end
    end
    @(negedge clk);
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset;
    issue(1, 16'h0010, 16'h0020, 1'b0, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL mid_handshake: got %b expected 1", ok); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (resp1_valid !== 1'b0) $display("FAIL mid_resp1_in_reset: got %b expected 0", resp1_valid); else pass_cnt++;
    total_cnt++; if (resp_result !== 16'h0000) $display("FAIL mid_result_in_reset: got %h expected 0000", resp_result); else pass_cnt++;
    rst = 1'b0;
    drive(0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    #1;
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL mid_idle_ready0: got %b expected 1", req0_ready); else pass_cnt++;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      total_cnt++; if (resp1_valid !== 1'b0) $display("FAIL mid_resp1_after: got %b expected 0", resp1_valid); else pass_cnt++;
      total_cnt++; if (resp_result !== 16'h0000) $display("FAIL mid_result_after: got %h expected 0000", resp_result); else pass_cnt++;
    end
    $display("reset_mid: req1 0010+0020 discarded, result=%h", resp_result);
  endtask

  task automatic test_random;
    logic        pend[2];
    logic [15:0] ra[2], rb[2];
    logic        rs[2];
    int          lg, cyc, due, next_idle, eo, g, done_ops, resp_seen;
    logic [15:0] er;
    logic [2:0]  ef;
    logic        idle, exp0, exp1, er0, er1;
    do_reset;
    pend = '{1'b0, 1'b0};
    lg = 1; cyc = 0; due = -1; next_idle = 0; eo = 0; done_ops = 0; resp_seen = 0;
    er = '0; ef = '0;
    while ((done_ops < 1000 || cyc <= due) && cyc < 20000) begin
      if (cyc != 0) @(negedge clk);
      exp0 = (cyc == due) && (eo == 0);
      exp1 = (cyc == due) && (eo == 1);
      total_cnt++; if (resp0_valid !== exp0) $display("FAIL rnd_resp0 cyc=%0d: got %b expected %b", cyc, resp0_valid, exp0); else pass_cnt++;
      total_cnt++; if (resp1_valid !== exp1) $display("FAIL rnd_resp1 cyc=%0d: got %b expected %b", cyc, resp1_valid, exp1); else pass_cnt++;
      if (cyc == due) begin
        resp_seen++;
        total_cnt++; if (resp_result !== er) $display("FAIL rnd_result cyc=%0d: got %h expected %h", cyc, resp_result, er); else pass_cnt++;
        total_cnt++; if (resp_flags !== ef) $display("FAIL rnd_flags cyc=%0d: got %b expected %b", cyc, resp_flags, ef); else pass_cnt++;
        $display("random: resp owner=%0d result=%h flags=%b", eo, resp_result, resp_flags);
      end
      for (int p = 0; p < 2; p++) begin
        if (done_ops >= 1000) pend[p] = 1'b0;
        else if (!pend[p] && $urandom_range(0, 3) != 0) begin
          pend[p] = 1'b1;
          ra[p] = rnd16();
          rb[p] = rnd16();
          rs[p] = 1'($urandom_range(0, 1));
        end
        drive(p, pend[p], pend[p] ? ra[p] : 16'h0, pend[p] ? rb[p] : 16'h0, pend[p] ? rs[p] : 1'b0);
      end
      #1;
      idle = (cyc >= next_idle);
      g    = (pend[0] && pend[1]) ? 1 - lg : (pend[1] ? 1 : 0);
      er0  = idle && pend[0] && (g == 0);
      er1  = idle && pend[1] && (g == 1);
      total_cnt++; if (req0_ready !== er0) $display("FAIL rnd_ready0 cyc=%0d: got %b expected %b", cyc, req0_ready, er0); else pass_cnt++;
      total_cnt++; if (req1_ready !== er1) $display("FAIL rnd_ready1 cyc=%0d: got %b expected %b", cyc, req1_ready, er1); else pass_cnt++;
      if (er0 || er1) begin
        ref_op(ra[g], rb[g], rs[g], er, ef);
        eo = g;
        due = cyc + 2;
        next_idle = cyc + 3;
        lg = g;
        pend[g] = 1'b0;
        done_ops++;
      end
      cyc++;
    end
    total_cnt++; if (done_ops !== 1000) $display("FAIL rnd_ops_done: got %0d expected 1000", done_ops); else pass_cnt++;
    total_cnt++; if (resp_seen !== 1000) $display("FAIL rnd_resp_count: got %0d expected 1000", resp_seen); else pass_cnt++;
    @(negedge clk);
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_saturation;
    test_contention;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
